pipe_rb_arbiter: RTL and testbench
==================================

# pipe_rb_arbiter

Round-robin scheduler that shares one two-stage pipelined OR-AND reduction unit among `N_REQ` requesters. Each requester offers a `W`-bit word over a valid/ready handshake. The block grants one requester per cycle and pushes the granted word through the reduction pipeline with its requester ID. It returns the 1-bit result, tagged with that ID, on a single response port with backpressure.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 8: data word width; must be even and at least 2.
- `IDW`, derived: `max(1, clog2(N_REQ))`, requester ID width.
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_req_valid` in `N_REQ`: per-requester request valid.
- `i_req_data` in `N_REQ*W`: requester k occupies bits `[k*W +: W]`.
- `o_req_ready` out `N_REQ`: one-hot grant.
  - A transfer for k occurs when `i_req_valid[k] & o_req_ready[k]`.
- `o_rsp_valid` out 1: result valid.
- `o_rsp_id` out `IDW`: requester index of the result.
- `o_rsp_data` out 1: reduction result.
- `i_rsp_ready` in 1: consumer accepts the result.
- `o_busy` out 1: at least one pipeline stage holds a valid entry.

## Operation
- **Reduction function:** `o_rsp_data = AND over j of (d[2j] | d[2j+1])`, for `j = 0..W/2-1`.
- **Pipeline stages:**
  - S1 registers `W/2` pair-OR bits, the ID and a valid bit.
  - S2 registers the AND of the S1 pair bits, the ID and a valid bit. S2 drives the `o_rsp_*` outputs directly.
- **Global advance enable:** `en = !o_rsp_valid | i_rsp_ready`.
  - When `en` = 0, S1, S2 and the round-robin pointer hold their values.
  - When `en` = 0, `o_req_ready` is all zeros.
- **Arbitration (combinational):**
  - Scan indices `rr_ptr, rr_ptr+1, … mod N_REQ`. The first k with `i_req_valid[k]` set wins.
  - `o_req_ready[k] = en & win[k]`.
  - `o_req_ready` is never asserted to a requester whose valid is low.
  - `o_req_ready` has at most one bit set.
- **Pointer update:**
  - On an accepted transfer from k: `rr_ptr <= (k+1) mod N_REQ`.
  - No transfer: `rr_ptr` holds.
- **S1 load:** when `en` = 1, S1 valid takes the value of "transfer occurred" this cycle. Bubbles propagate as invalid entries.
- **Request rules:**
  - A requester may drop or change `i_req_valid` / `i_req_data` while not granted.
  - No data is captured without a transfer.
- **Response rules:**
  - `o_rsp_valid`, `o_rsp_id` and `o_rsp_data` stay stable while `o_rsp_valid & !i_rsp_ready`.
  - The response retires on `o_rsp_valid & i_rsp_ready`.
- **Busy:** `o_busy = S1.valid | S2.valid`.
- **Reset values (cycle after `i_rst` = 1):**
  - S1/S2 valid = 0, `rr_ptr` = 0.
  - `o_rsp_valid` = 0, `o_rsp_id` = 0, `o_rsp_data` = 0, `o_busy` = 0.
  - `o_req_ready` = 0 while `i_rst` is high.
- **Reset mid-operation:** all in-flight entries are discarded with no response. Arbitration restarts at index 0.

## Timing
- **Latency:** a transfer in cycle t gives `o_rsp_valid` = 1 in cycle t+2, provided `en` stays 1.
- **Throughput:** one transfer per cycle while `i_rsp_ready` = 1. Back-to-back transfers produce consecutive responses in grant order.
- **Stall:** each cycle of `o_rsp_valid & !i_rsp_ready` adds one cycle of latency to every in-flight entry. No entry is lost or duplicated.
- **Simultaneous retire and grant:** with `o_rsp_valid` = 1 and `i_rsp_ready` = 1, a new transfer is accepted in the same cycle (full throughput).
- **Pointer wrap:** a grant to `N_REQ-1` sets `rr_ptr` = 0.
- **Ordering:** responses leave in the same order as grants.

## Test plan
- **Single request, result 1:** reset, then requester 2 drives `8'b01010101`.
  - Required: `o_req_ready = 4'b0100` in cycle t.
  - Required: `o_rsp_valid` = 1, `o_rsp_id` = 2, `o_rsp_data` = 1 at t+2.
- **Single request, result 0:** requester 0 drives `8'b00000011`.
  - Required: response `id` = 0, `data` = 0, two cycles after the grant.
- **Fairness:** all four valids held high with `i_rsp_ready` = 1 for 8 cycles.
  - Required: grants 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Required: responses with the same IDs in order, starting 2 cycles later.
- **Backpressure:** continuous requests from requester 1; drop `i_rsp_ready` for 3 cycles while a response is valid.
  - Required: `o_req_ready` = 0 and outputs frozen for those 3 cycles.
  - Required: after release, the held response retires, then the next one, with no loss or duplication.
- **Reset mid-flight:** grant in cycle t, `i_rst` pulse in cycle t+1.
  - Required: no `o_rsp_valid` at t+2; `o_busy` = 0.
  - Required: with 0 and 3 both valid afterwards, the first grant goes to 0.
- **Pointer skip/wrap:** `rr_ptr` = 3 with only requester 1 valid.
  - Required: grant 1, then `rr_ptr` = 2.

Source files
------------

// File: rtl/pipe_rb_arbiter.sv
// rtl/pipe_rb_arbiter.sv - round-robin requester arbiter feeding a two-stage OR-AND reduction pipeline
module pipe_rb_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  localparam int IDW  = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ*W-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_rsp_valid,
  output logic [IDW-1:0]     o_rsp_id,
  output logic               o_rsp_data,
  input  logic               i_rsp_ready,
  output logic               o_busy
);

  localparam int NP = W / 2;

  // Round-robin pointer: index that gets first look in the next arbitration.
  logic [IDW-1:0] rr_ptr;

  // Stage 1: pair-OR bits of the granted word.
  logic           s1_valid;
  logic [NP-1:0]  s1_pair;
  logic [IDW-1:0] s1_id;

  // Stage 2: final AND; this stage is the response port.
  logic           s2_valid;
  logic           s2_data;
  logic [IDW-1:0] s2_id;

  logic           en;
  logic           found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic [N_REQ-1:0] win;
  logic           xfer;
  logic [W-1:0]   sel_data;
  logic [NP-1:0]  pair_or;
  logic [IDW-1:0] next_ptr;

  // Advance (base + off) around the ring of N_REQ requesters.
  function automatic logic [IDW-1:0] ring_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  // The whole pipeline moves only when the response slot is empty or being drained.
  assign en = !s2_valid || i_rsp_ready;

  // Scan from rr_ptr upward and pick the first requester with valid set.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ring_add(rr_ptr, i);
      if (!found && i_req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // One-hot grant, suppressed during stall and reset.
  always_comb begin
    win = '0;
    if (found) win[win_id] = 1'b1;
    o_req_ready = (en && !i_rst) ? win : '0;
  end

  assign xfer = |o_req_ready;

  // Pair-OR of the granted word, the first half of the reduction.
  always_comb begin
    sel_data = i_req_data[int'(win_id)*W +: W];
    pair_or  = '0;
    for (int j = 0; j < NP; j++) begin
      pair_or[j] = sel_data[2*j] | sel_data[2*j+1];
    end
  end

  // The winner's successor becomes the next first-look index, wrapping to 0.
  assign next_ptr = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;

  // Pipeline stages and pointer, all frozen together while the response is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_pair  <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_data  <= 1'b0;
      s2_id    <= '0;
    end else if (en) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_pair <= pair_or;
        s1_id   <= win_id;
        rr_ptr  <= next_ptr;
      end
      s2_valid <= s1_valid;
      s2_data  <= s1_valid & (&s1_pair);
      s2_id    <= s1_valid ? s1_id : '0;
    end
  end

  assign o_rsp_valid = s2_valid;
  assign o_rsp_id    = s2_id;
  assign o_rsp_data  = s2_data;
  assign o_busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_pipe_rb_arbiter.sv
// tb/tb_pipe_rb_arbiter.sv - directed bench with queue-based reference model for pipe_rb_arbiter
module tb_pipe_rb_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ*W-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_data;
  logic               rsp_ready = 1'b1;
  logic               busy;

  int checks = 0;
  int errors = 0;

  pipe_rb_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight responses in grant order, each with advances left until visible.
  int q_id[$];
  int q_dat[$];
  int q_rem[$];
  int mptr = 0;
  bit armed = 1'b0;
  bit m_en;
  int m_g;

  function automatic int pick(input int ptr, input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) begin
      if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    end
    return -1;
  endfunction

  function automatic int reduce(input logic [W-1:0] d);
    int r;
    r = 1;
    for (int j = 0; j < W / 2; j++) r = r & int'(d[2*j] | d[2*j+1]);
    return r;
  endfunction

  function automatic bit m_valid();
    return (q_rem.size() > 0) && (q_rem[0] == 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q_id.delete(); q_dat.delete(); q_rem.delete();
      mptr  = 0;
      armed = 1'b1;
    end else if (armed) begin
      m_en = !m_valid() || rsp_ready;
      m_g  = pick(mptr, req_valid);
      if (m_en) begin
        if (m_valid() && rsp_ready) begin
          void'(q_id.pop_front()); void'(q_dat.pop_front()); void'(q_rem.pop_front());
        end
        foreach (q_rem[i]) if (q_rem[i] > 0) q_rem[i] = q_rem[i] - 1;
        if (m_g >= 0) begin
          q_id.push_back(m_g);
          q_dat.push_back(reduce(req_data[m_g*W +: W]));
          q_rem.push_back(1);
          mptr = (m_g + 1) % N_REQ;
        end
      end
    end
  end

  logic [N_REQ-1:0] exp_ready;
  int cg;

  always @(negedge clk) begin
    if (armed) begin
      exp_ready = '0;
      cg = pick(mptr, req_valid);
      if (!rst && (!m_valid() || rsp_ready) && cg >= 0) exp_ready[cg] = 1'b1;
      check("model_ready", 32'(req_ready), 32'(exp_ready));
      check("model_rsp_valid", 32'(rsp_valid), 32'(m_valid()));
      check("model_busy", 32'(busy), 32'(q_rem.size() > 0));
      if (m_valid()) begin
        check("model_rsp_id", 32'(rsp_id), 32'(q_id[0]));
        check("model_rsp_data", 32'(rsp_data), 32'(q_dat[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] fair_data [N_REQ];
  int fair_res [N_REQ];
  int n_bp;
  bit granted;

  initial begin
    fair_data[0] = 8'hFF; fair_data[1] = 8'h00; fair_data[2] = 8'hAA; fair_data[3] = 8'h0F;
    fair_res[0]  = 1;     fair_res[1]  = 0;     fair_res[2]  = 1;     fair_res[3]  = 0;

    // Reset with all requesters asking: no grant may appear.
    req_valid = '1;
    #2 check("rst_ready", 32'(req_ready), 32'h0);
    tick(); tick();
    check("rst_ready2", 32'(req_ready), 32'h0);
    rst = 1'b0;
    req_valid = '0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single request from 2, result 1.
    req_valid = 4'b0100;
    req_data[2*W +: W] = 8'b0101_0101;
    #1 check("single1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1 check("single1_t1_valid", 32'(rsp_valid), 32'h0);
    tick();
    #1;
    check("single1_valid", 32'(rsp_valid), 32'h1);
    check("single1_id", 32'(rsp_id), 32'h2);
    check("single1_data", 32'(rsp_data), 32'h1);

    // Single request from 0, result 0.
    req_valid = 4'b0001;
    req_data[0 +: W] = 8'b0000_0011;
    #1 check("single0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    #1;
    check("single0_valid", 32'(rsp_valid), 32'h1);
    check("single0_id", 32'(rsp_id), 32'h0);
    check("single0_data", 32'(rsp_data), 32'h0);
    tick();

    // Fairness from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N_REQ; k++) req_data[k*W +: W] = fair_data[k];
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) check("fair_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check("fair_rsp_valid", 32'(rsp_valid), 32'h1);
        check("fair_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
        check("fair_rsp_data", 32'(rsp_data), 32'(fair_res[(c - 2) % 4]));
      end
      tick();
    end
    tick();

    // Backpressure with requester 1 streaming alternating words.
    n_bp = 0;
    req_data[1*W +: W] = 8'h55;
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      rsp_ready = !(c >= 2 && c <= 4);
      if (c == 8) req_valid = '0;
      #1;
      if (c < 2) check("bp_grant", 32'(req_ready), 32'h2);
      if (c >= 2 && c <= 4) begin
        check("bp_stall_ready", 32'(req_ready), 32'h0);
        check("bp_stall_valid", 32'(rsp_valid), 32'h1);
        check("bp_stall_id", 32'(rsp_id), 32'h1);
        check("bp_stall_data", 32'(rsp_data), 32'h1);
      end
      if (c == 5) begin
        check("bp_release_grant", 32'(req_ready), 32'h2);
        check("bp_release_data", 32'(rsp_data), 32'h1);
      end
      if (c == 6) begin
        check("bp_next_valid", 32'(rsp_valid), 32'h1);
        check("bp_next_data", 32'(rsp_data), 32'h0);
      end
      granted = req_ready[1];
      tick();
      if (granted) begin
        n_bp++;
        req_data[1*W +: W] = (n_bp % 2 == 1) ? 8'h00 : 8'h55;
      end
    end
    rsp_ready = 1'b1;
    tick(); tick();

    // Reset mid-flight: pointer sits at 2, grant 2, then reset.
    req_valid = 4'b0100;
    req_data[2*W +: W] = 8'hFF;
    #1 check("midrst_grant", 32'(req_ready), 32'h4);
    tick();
    rst = 1'b1;
    req_valid = '0;
    #1 check("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    check("midrst_no_rsp", 32'(rsp_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_first_grant", 32'(req_ready), 32'h1);
    tick();

    // Pointer skip: bring pointer to 3, offer only 1, then confirm pointer is 2.
    req_valid = 4'b0100;
    #1 check("skip_setup", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0010;
    #1 check("skip_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0110;
    #1 check("skip_ptr2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
